// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access sequencer: transfer sizes, error
// codes, read/write polarity and the FSM state type.
package mem_access_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_MFC = 3'd2,
      ST_RELEASE  = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   // True when the low address bits do not match the natural alignment of size.
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_low);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_HALF:  bad = addr_low[0];
         SZ_WORD:  bad = |addr_low[1:0];
         SZ_DWORD: bad = |addr_low;
         default:  bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational load-data extension: byte and halfword results are sign- or
// zero-extended to the full data width; word and doubleword pass through.
module load_extend
   import mem_access_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   output logic [DATA_W-1:0] result
);

   // Select the valid low bits and fill the rest with the sign bit or zeros.
   always_comb begin
      result = data;
      case (size)
         SZ_BYTE: result = {{(DATA_W-8){sign_ext & data[7]}}, data[7:0]};
         SZ_HALF: result = {{(DATA_W-16){sign_ext & data[15]}}, data[15:0]};
         default: result = data;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between the control unit and the ram: accepts one load/store,
// checks alignment, drives and holds the ram request until mfc, splits
// doublewords into two word transfers, extends load data and reports
// completion with a done pulse plus an error code. A watchdog bounds the
// wait for mfc.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W         = 9,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              req_rw,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata_lo,
   input  logic [DATA_W-1:0] req_wdata_hi,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err,
   output logic [DATA_W-1:0] rdata_lo,
   output logic [DATA_W-1:0] rdata_hi,
   output logic              ram_enable,
   output logic              ram_read_write,
   output logic [1:0]        ram_data_length,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out,
   input  logic              ram_mfc,
   output state_t            fsm_state
);

   localparam int                WD_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

   state_t              state;
   logic                rw_q;
   logic [1:0]          size_q;
   logic                sign_q;
   logic                second_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_hi_q;
   logic [DATA_W-1:0]   cap_lo;
   logic [DATA_W-1:0]   cap_hi;
   logic [WD_W-1:0]     wd_cnt;
   logic [DATA_W-1:0]   ext_lo;

   assign fsm_state = state;

   load_extend #(.DATA_W(DATA_W)) u_load_extend (
      .data     (cap_lo),
      .size     (size_q),
      .sign_ext (sign_q),
      .result   (ext_lo)
   );

   // Transaction FSM: request latch, ram drive/hold, mfc capture with
   // watchdog, mfc release handshake and completion reporting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         rw_q            <= 1'b0;
         size_q          <= SZ_BYTE;
         sign_q          <= 1'b0;
         second_q        <= 1'b0;
         addr_q          <= '0;
         wdata_hi_q      <= '0;
         cap_lo          <= '0;
         cap_hi          <= '0;
         wd_cnt          <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= ERR_NONE;
         rdata_lo        <= '0;
         rdata_hi        <= '0;
         ram_enable      <= 1'b0;
         ram_read_write  <= 1'b0;
         ram_data_length <= 2'b00;
         ram_address     <= '0;
         ram_data_in     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  rw_q       <= req_rw;
                  size_q     <= req_size;
                  sign_q     <= req_signed;
                  addr_q     <= req_addr;
                  wdata_hi_q <= req_wdata_hi;
                  second_q   <= 1'b0;
                  busy       <= 1'b1;
                  if (misaligned(req_size, req_addr[2:0])) begin
                     // Rejected before any ram traffic.
                     err   <= ERR_ALIGN;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     err             <= ERR_NONE;
                     ram_enable      <= 1'b1;
                     ram_read_write  <= req_rw;
                     ram_data_length <= (req_size == SZ_DWORD) ? SZ_WORD : req_size;
                     ram_address     <= req_addr;
                     ram_data_in     <= req_wdata_lo;
                     state           <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               wd_cnt <= '0;
               state  <= ST_WAIT_MFC;
            end
            ST_WAIT_MFC: begin
               if (ram_mfc) begin
                  if (second_q) cap_hi <= ram_data_out;
                  else          cap_lo <= ram_data_out;
                  ram_enable <= 1'b0;
                  state      <= ST_RELEASE;
               end else if (wd_cnt == WD_LAST) begin
                  // Give up on this transfer; any remaining dword half is skipped.
                  ram_enable <= 1'b0;
                  err        <= ERR_TIMEOUT;
                  done       <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               // Proceed only once mfc is low so a stale mfc cannot finish the next transfer.
               if (!ram_mfc) begin
                  if (size_q == SZ_DWORD && !second_q) begin
                     second_q    <= 1'b1;
                     ram_address <= addr_q + WORD_STEP;
                     ram_data_in <= wdata_hi_q;
                     ram_enable  <= 1'b1;
                     state       <= ST_ISSUE;
                  end else begin
                     if (rw_q == RW_READ) begin
                        rdata_lo <= ext_lo;
                        rdata_hi <= (size_q == SZ_DWORD) ? cap_hi : '0;
                     end
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer between the control unit and the ram block. Accepts one load/store request per transaction, checks alignment, drives the ram's enable/read_write/data_length/address/data_in and holds them until mfc. Splits doubleword accesses into two word transfers, and sign- or zero-extends load data. Reports completion with a one-cycle done pulse and an error code; a watchdog covers an mfc that never arrives.

Parameters:
ADDR_W, 9, ram address width
DATA_W, 32, ram data width
TIMEOUT_CYCLES, 16, cycles in WAIT_MFC before a timeout error

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  start request; sampled only in IDLE
req_rw  in  1  1 = read (load), 0 = write (store); same encoding as ram read_write
req_size  in  2  00 byte, 01 halfword, 10 word, 11 doubleword
req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend
req_addr  in  ADDR_W  byte address
req_wdata_lo  in  DATA_W  store data, low word (byte/halfword right-justified)
req_wdata_hi  in  DATA_W  store data, high word (doubleword only)
busy  out  1  high from accept through done
done  out  1  one-cycle completion pulse
err  out  2  00 ok, 01 misaligned, 10 timeout; valid with done, held until next accept
rdata_lo  out  DATA_W  load result, low word, extended
rdata_hi  out  DATA_W  load result, high word (doubleword only, else 0)
ram_enable  out  1  to ram enable
ram_read_write  out  1  to ram read_write
ram_data_length  out  2  to ram data_length (00/01/10 only; never 11)
ram_address  out  ADDR_W  to ram address
ram_data_in  out  DATA_W  to ram data_in
ram_data_out  in  DATA_W  from ram data_out; byte in [7:0], halfword in [15:0]
ram_mfc  in  1  from ram mfc (memory function complete)

Behaviour:
- Reset (async): state IDLE. busy, done, ram_enable and ram_read_write are 0. err = 00. All data/address outputs are 0.
- Latched on accept (IDLE and req=1): rw, size, signed, addr, wdata_lo/hi. Request inputs are ignored at all other times.
- Alignment check on accept:
  - halfword: addr[0] must be 0
  - word: addr[1:0] must be 0
  - doubleword: addr[2:0] must be 0
  - On violation: go to DONE with err=01. No ram_enable pulse is issued.
- States: IDLE -> ISSUE -> WAIT_MFC -> RELEASE -> (ISSUE for the second dword half | DONE) -> IDLE.
  - ISSUE (1 cycle): drive ram_* from the latched fields and set ram_enable=1. Doubleword uses ram_data_length=10. The first half goes to addr with wdata_lo; the second half goes to addr+4 with wdata_hi.
  - WAIT_MFC: ram_* held stable with enable=1. On the edge where ram_mfc=1, capture ram_data_out (loads), drop ram_enable, and go to RELEASE. A watchdog counter increments each cycle; when it reaches TIMEOUT_CYCLES without mfc, drop enable and go to DONE with err=10. A timeout in the first dword half skips the second half.
  - RELEASE: wait for ram_mfc=0, then proceed. This prevents a stale mfc from completing the next transfer.
  - DONE (1 cycle): done=1 and busy=0 on the following cycle. A req in the DONE cycle is ignored; a req in the next IDLE cycle is accepted.
- Load extension:
  - byte: [7:0], extended to 32 bits with bit 7 or zeros
  - halfword: [15:0], extended with bit 15 or zeros
  - word and doubleword: no extension
  - rdata_* are updated only on successful loads; stores leave them unchanged.
- Minimum latency (mfc returned one cycle after enable), accept to done: single transfer 4 cycles, doubleword 7 cycles.
- Address arithmetic is ADDR_W-bit. Aligned doublewords never wrap (max 0x1F8 + 4 = 0x1FC).
- Reset mid-transaction: enable drops immediately and the transaction is abandoned. No done pulse is produced.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD
  - err codes ERR_NONE, ERR_ALIGN, ERR_TIMEOUT
  - state encodings
  - RW_READ=1, RW_WRITE=0
- One natural sub-module: load_extend. It is combinational: data, size and signed in; 32-bit extended result out.
- FSM, watchdog counter and capture registers stay in mem_access_ctrl.

Test Plan:
- Signed byte load, addr 0x005, ram returns 0x00000080 -> rdata_lo=0xFFFFFF80, err=00, done 4 cycles after accept. The same load with req_signed=0 -> 0x00000080.
- Word store, addr 0x010, wdata_lo=0xDEADBEEF -> ram_read_write=0, ram_data_length=10, ram_address=0x010, ram_data_in=0xDEADBEEF held until mfc; done, err=00.
- Misaligned halfword load, addr 0x003 -> ram_enable never rises, done with err=01.
- Doubleword load, addr 0x008 -> two enables at 0x008 and 0x00C. rdata_lo/rdata_hi equal the respective ram words. mfc is held high for 3 cycles after the first capture and the second ISSUE waits for it to fall.
- mfc tied 0 on a word read -> enable drops and done asserts with err=10 after 16 WAIT_MFC cycles. A req pulse during busy is ignored.
- Reset asserted mid-WAIT_MFC -> ram_enable=0, busy=0, err=00 asynchronously; no done pulse. The next req completes normally.
